// File: rtl/pause_dim_ctl_pkg.sv
// Shared types and helpers for the pause/dim controller.
package pause_pkg;

    // Controller modes: running, user-paused, armed for a frame step, running the stepped frame
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PAUSED   = 2'd1,
        STEP_ARM = 2'd2,
        STEP_RUN = 2'd3
    } pause_state_t;

    // Number of colour channels carried on the packed {R,G,B} bus
    localparam int NUM_CH = 3;

    // Width of a counter able to hold 0..cycles; never narrower than one bit
    function automatic int timer_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pause_dim_ctl_rgb_dimmer.sv
// Per-pixel RGB register that attenuates every channel by a fixed right shift
// while dimming is requested. Updates only on ce_pix and holds in between.
module rgb_dimmer
    import pause_pkg::*;
#(
    parameter int COLOR_W   = 4,
    parameter int DIM_SHIFT = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce_pix,
    input  logic                      dim,
    input  logic [NUM_CH*COLOR_W-1:0] rgb_in,
    output logic [NUM_CH*COLOR_W-1:0] rgb_out
);

    logic [NUM_CH*COLOR_W-1:0] shifted;

    // Shift each channel on its own so no bits leak from one colour into the next
    always_comb begin
        shifted = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            shifted[c*COLOR_W +: COLOR_W] = rgb_in[c*COLOR_W +: COLOR_W] >> DIM_SHIFT;
        end
    end

    // Capture the pixel on the pixel enable, choosing the attenuated or original colour
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rgb_out <= '0;
        end else if (ce_pix) begin
            rgb_out <= dim ? shifted : rgb_in;
        end
    end

endmodule

// File: rtl/pause_dim_ctl.sv
// Pause/dim controller for arcade cores. Merges external pause requests with a
// user pause toggle, supports single-frame stepping while paused, and dims the
// video after a programmable idle time.
// Optional build macro PAUSE_OSD_EN adds an osd_status input: an open menu
// forces the core paused and counts as idle time, without touching the mode.
module pause_dim_ctl
    import pause_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int COLOR_W    = 4,
    parameter int DIM_CYCLES = 240000000,
    parameter int DIM_SHIFT  = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      pause_btn,
    input  logic                      step_btn,
    input  logic [NUM_SRC-1:0]        pause_src,
    input  logic                      vblank,
    input  logic                      ce_pix,
    input  logic [NUM_CH*COLOR_W-1:0] rgb_in,
`ifdef PAUSE_OSD_EN
    input  logic                      osd_status,
`endif
    output logic                      pause,
    output logic                      user_paused,
    output logic                      dimmed,
    output logic [NUM_CH*COLOR_W-1:0] rgb_out
);

    localparam int            TW      = timer_width(DIM_CYCLES);
    localparam logic [TW-1:0] DIM_MAX = TW'(DIM_CYCLES);
    localparam bit            DIM_EN  = (DIM_CYCLES != 0);

    pause_state_t  state;
    logic          pause_btn_q;
    logic          step_btn_q;
    logic          vblank_q;
    logic          pause_edge;
    logic          step_edge;
    logic          vblank_edge;
    logic          osd;
    logic          timer_en;
    logic [TW-1:0] timer;

`ifdef PAUSE_OSD_EN
    assign osd = osd_status;
`else
    assign osd = 1'b0;
`endif

    assign pause_edge  = pause_btn & ~pause_btn_q;
    assign step_edge   = step_btn  & ~step_btn_q;
    assign vblank_edge = vblank    & ~vblank_q;

    // The stepped frame itself is not idle time; an open menu is
    assign timer_en = (state == PAUSED) | (state == STEP_ARM) | osd;

    // Remember last level of each level input so rising edges can be spotted
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pause_btn_q <= 1'b0;
            step_btn_q  <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            pause_btn_q <= pause_btn;
            step_btn_q  <= step_btn;
            vblank_q    <= vblank;
        end
    end

    // Mode machine plus its registered outputs; pause button edges always take priority
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pause       <= 1'b0;
            user_paused <= 1'b0;
        end else begin
            pause       <= (|pause_src) | (state == PAUSED) | (state == STEP_ARM) | osd;
            user_paused <= (state != RUN);
            case (state)
                RUN: begin
                    if (pause_edge) state <= PAUSED;
                end
                PAUSED: begin
                    if (pause_edge)     state <= RUN;
                    else if (step_edge) state <= STEP_ARM;
                end
                STEP_ARM: begin
                    if (pause_edge)       state <= RUN;
                    else if (vblank_edge) state <= STEP_RUN;
                end
                STEP_RUN: begin
                    if (pause_edge)       state <= RUN;
                    else if (vblank_edge) state <= PAUSED;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Idle timer: counts up to DIM_CYCLES while idle, restarts on any pause press
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (pause_edge | ~timer_en) begin
            timer <= '0;
        end else if (timer != DIM_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    // Dim once the idle timer has saturated, unless dimming is disabled altogether
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dimmed <= 1'b0;
        end else begin
            dimmed <= DIM_EN & (timer == DIM_MAX);
        end
    end

    rgb_dimmer #(
        .COLOR_W   (COLOR_W),
        .DIM_SHIFT (DIM_SHIFT)
    ) u_dimmer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .dim     (dimmed),
        .rgb_in  (rgb_in),
        .rgb_out (rgb_out)
    );

endmodule

// File: tb/tb_pause_dim_ctl.sv
// Testbench for pause_dim_ctl: directed scenarios followed by random stimulus,
// all checked per clock against a behavioural model through a scoreboard queue.
module tb_pause_dim_ctl;

    localparam int NUM_SRC    = 2;
    localparam int COLOR_W    = 4;
    localparam int DIM_CYCLES = 16;
    localparam int DIM_SHIFT  = 1;
    localparam int RGB_W      = 3 * COLOR_W;

    logic               clk_sys = 1'b0;
    logic               reset   = 1'b1;
    logic               pause_btn = 1'b0;
    logic               step_btn  = 1'b0;
    logic [NUM_SRC-1:0] pause_src = '0;
    logic               vblank    = 1'b0;
    logic               ce_pix    = 1'b0;
    logic [RGB_W-1:0]   rgb_in    = '0;
    logic               pause;
    logic               user_paused;
    logic               dimmed;
    logic [RGB_W-1:0]   rgb_out;
`ifdef PAUSE_OSD_EN
    logic               osd_status = 1'b0;
`endif

    pause_dim_ctl #(
        .NUM_SRC    (NUM_SRC),
        .COLOR_W    (COLOR_W),
        .DIM_CYCLES (DIM_CYCLES),
        .DIM_SHIFT  (DIM_SHIFT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .pause_btn   (pause_btn),
        .step_btn    (step_btn),
        .pause_src   (pause_src),
        .vblank      (vblank),
        .ce_pix      (ce_pix),
        .rgb_in      (rgb_in),
`ifdef PAUSE_OSD_EN
        .osd_status  (osd_status),
`endif
        .pause       (pause),
        .user_paused (user_paused),
        .dimmed      (dimmed),
        .rgb_out     (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic             pause;
        logic             user;
        logic             dim;
        logic [RGB_W-1:0] rgb;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Behavioural model: user toggle, frame-step phase, idle count, last levels, outputs
    bit               m_user;
    bit               m_step_wait;
    bit               m_step_frame;
    int               m_idle;
    bit               m_prev_pb, m_prev_sb, m_prev_vb;
    bit               e_pause, e_user, e_dim;
    logic [RGB_W-1:0] e_rgb;

    // Current driven levels for the directed and random phases
    bit               cur_pb, cur_sb, cur_vb, cur_ce;
    bit [1:0]         cur_src;
    logic [RGB_W-1:0] cur_rgb;

    function automatic logic [RGB_W-1:0] dimColour(input logic [RGB_W-1:0] c);
        int div;
        int r, g, b;
        div = 1 << DIM_SHIFT;
        r = int'(c[11:8]) / div;
        g = int'(c[7:4])  / div;
        b = int'(c[3:0])  / div;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic modelReset();
        m_user = 0; m_step_wait = 0; m_step_frame = 0; m_idle = 0;
        m_prev_pb = 0; m_prev_sb = 0; m_prev_vb = 0;
        e_pause = 0; e_user = 0; e_dim = 0; e_rgb = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one clock of inputs and queue what the outputs must show after the next edge
    task automatic applyStimulus(input bit pb, input bit sb, input bit [1:0] src,
                                 input bit vb, input bit ce, input logic [RGB_W-1:0] rgb);
        bit pe, se, ve, counting;
        exp_t e;
        @(negedge clk_sys);
        pause_btn = pb; step_btn = sb; pause_src = src; vblank = vb;
        ce_pix = ce; rgb_in = rgb;
        pe = pb && !m_prev_pb;
        se = sb && !m_prev_sb;
        ve = vb && !m_prev_vb;
        e.pause = (src != 0) || (m_user && !m_step_frame);
        e.user  = m_user;
        e.dim   = (DIM_CYCLES != 0) && (m_idle == DIM_CYCLES);
        e.rgb   = ce ? (e_dim ? dimColour(rgb) : rgb) : e_rgb;
        counting = m_user && !m_step_frame;
        if (pe || !counting) m_idle = 0;
        else if (m_idle < DIM_CYCLES) m_idle = m_idle + 1;
        if (pe) begin
            m_user = !m_user; m_step_wait = 0; m_step_frame = 0;
        end else if (m_user) begin
            if (m_step_frame) begin
                if (ve) m_step_frame = 0;
            end else if (m_step_wait) begin
                if (ve) begin m_step_wait = 0; m_step_frame = 1; end
            end else if (se) begin
                m_step_wait = 1;
            end
        end
        m_prev_pb = pb; m_prev_sb = sb; m_prev_vb = vb;
        e_pause = e.pause; e_user = e.user; e_dim = e.dim; e_rgb = e.rgb;
        sb_q.push_back(e);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(cur_pb, cur_sb, cur_src, cur_vb, cur_ce, cur_rgb);
    endtask

    task automatic pulsePause();
        cur_pb = 1; runCycles(2); cur_pb = 0; runCycles(3);
    endtask

    task automatic pulseStep();
        cur_sb = 1; runCycles(1); cur_sb = 0; runCycles(3);
    endtask

    task automatic frameEdge(input int gap);
        cur_vb = 1; runCycles(2); cur_vb = 0; runCycles(gap);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        pause_btn = 0; step_btn = 0; pause_src = '0; vblank = 0; ce_pix = 0; rgb_in = '0;
        cur_pb = 0; cur_sb = 0; cur_vb = 0; cur_src = 0; cur_ce = 1; cur_rgb = '0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        modelReset();
    endtask

    // Raise reset between clock edges and expect every output cleared straight away
    task automatic asyncResetCheck();
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_pause", pause, 0);
        checkOutput("async_reset_user_paused", user_paused, 0);
        checkOutput("async_reset_dimmed", dimmed, 0);
        checkOutput("async_reset_rgb_out", rgb_out, 0);
        @(negedge clk_sys);
        pause_btn = 0; step_btn = 0; pause_src = '0; vblank = 0;
        cur_pb = 0; cur_sb = 0; cur_vb = 0; cur_src = 0;
        reset = 1'b0;
        modelReset();
    endtask

    // Scoreboard monitor: pop one expectation per clock and compare every output
    always begin
        @(posedge clk_sys);
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("pause", pause, e.pause);
            checkOutput("user_paused", user_paused, e.user);
            checkOutput("dimmed", dimmed, e.dim);
            checkOutput("rgb_out", rgb_out, e.rgb);
        end
    end

    initial begin
        int frame_pos;
        modelReset();
        resetDut();
        runCycles(3);

        // User toggle on and off
        pulsePause();
        runCycles(4);
        pulsePause();
        runCycles(4);

        // External request only: pause without ever dimming
        cur_src = 2'b10; runCycles(2 * DIM_CYCLES + 4);
        cur_src = 2'b00; runCycles(3);

        // Idle long enough to dim, then check attenuation and hold between pixel enables
        pulsePause();
        cur_rgb = 12'hFA8; runCycles(DIM_CYCLES + 6);
        cur_ce = 0; cur_rgb = 12'h123; runCycles(4);
        cur_ce = 1; runCycles(2);

        // Single frame step: armed, one frame released, back to paused
        pulseStep();
        runCycles(5);
        frameEdge(10);
        frameEdge(6);

        // Pause and step pressed together while paused: pause wins, back to running
        cur_pb = 1; cur_sb = 1; runCycles(1);
        cur_pb = 0; cur_sb = 0; runCycles(4);

        // Pause press coinciding with the releasing vblank edge
        pulsePause();
        pulseStep();
        cur_pb = 1; cur_vb = 1; runCycles(1);
        cur_pb = 0; cur_vb = 0; runCycles(4);

        // Enter the stepped frame and reset in the middle of it
        pulsePause();
        pulseStep();
        cur_rgb = 12'h9C3;
        frameEdge(3);
        asyncResetCheck();
        runCycles(3);

        // Random phase
        frame_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cur_pb = !cur_pb;
            if ($urandom_range(0, 7) == 0)  cur_sb = !cur_sb;
            if ($urandom_range(0, 59) == 0) cur_src = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            cur_vb  = (frame_pos < 3);
            frame_pos = (frame_pos + 1) % (20 + int'($urandom_range(0, 8)));
            cur_ce  = 1'($urandom_range(0, 1));
            cur_rgb = 12'($urandom);
            applyStimulus(cur_pb, cur_sb, cur_src, cur_vb, cur_ce, cur_rgb);
        end

        repeat (3) @(negedge clk_sys);
        checkOutput("queue_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
